mem_arb_2x1: RTL
================

Name: mem_arb_2x1

Overview:
- Shares the single sram-like port of axi_ctrl between two masters: m0 (instruction fetch) and m1 (data side, after CLINT decode).
- Allows only one outstanding transaction at a time.
- Latches the winning master's request, sequences the slave's address-accept and data-complete handshake, and routes the completion back to the owner.
- Sits between the core's fetch/data ports and the data-bridge/axi_ctrl path.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width. Byte-enable width is DATA_W/8.
- RR_MODE, 0, arbitration mode. 0 = fixed priority (m1 wins). 1 = round-robin.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- m0_req  in  1  m0 request; held with fields stable until m0_gnt
- m0_we  in  DATA_W/8  m0 byte write enable; 0 = read
- m0_addr  in  ADDR_W  m0 address
- m0_wdata  in  DATA_W  m0 write data
- m0_gnt  out  1  m0 request accepted by slave (pulse)
- m0_rvalid  out  1  m0 transaction complete (pulse)
- m0_rdata  out  DATA_W  m0 read data, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for m1
- s_req  out  1  request to slave
- s_we  out  DATA_W/8  latched write enable
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_addr_ok  in  1  slave accepts request this cycle
- s_data_ok  in  1  slave completes transaction this cycle
- s_rdata  in  DATA_W  slave read data, valid with s_data_ok

Behaviour:
- States: IDLE, REQ, RESP. Registers: state, owner (1 bit), last_owner (1 bit), latched we/addr/wdata.
- Reset values:
  - state = IDLE, owner = 0, last_owner = 1.
  - Latched fields = 0, so s_req/s_we/s_addr/s_wdata = 0.
  - All mN_gnt/mN_rvalid = 0. mN_rdata = 0.
- Arbitration, evaluated in IDLE and in RESP on the s_data_ok cycle:
  - Exactly one requester: it wins.
  - Both request, RR_MODE=0: m1 wins.
  - Both request, RR_MODE=1: the master != last_owner wins.
  - On a win: owner <= winner, last_owner <= winner, winner's we/addr/wdata captured, state <= REQ.
- IDLE: s_req=0. No request -> stay in IDLE.
- REQ:
  - s_req=1; s_we/s_addr/s_wdata driven from latches only, never combinationally from the master inputs.
  - s_addr_ok=1 -> m<owner>_gnt=1 in the same cycle (combinational), state <= RESP.
  - Otherwise hold, with no timeout.
  - s_data_ok in REQ is ignored.
- RESP:
  - s_req=0.
  - s_data_ok=1 -> m<owner>_rvalid=1 and m<owner>_rdata=s_rdata in the same cycle.
  - mN_rdata is registered-held: it keeps the last completed value for its master until that master's next rvalid.
  - Writes complete the same way; rdata is then don't-care but is still captured.
  - In the s_data_ok cycle: if any request is pending, arbitrate and go directly to REQ; else go to IDLE.
- Master inputs are sampled only at arbitration. The loser keeps req asserted, and its fields must stay stable until its own gnt.
- The non-owner's gnt/rvalid are always 0. gnt and rvalid are never both asserted to one master in the same cycle.
- Minimum latency:
  - req at T -> s_req at T+1.
  - gnt at T+1 if addr_ok at T+1.
  - rvalid at T+2 if data_ok at T+2.
  - Back-to-back: next s_req at T+3.
- Reset mid-transaction: all state returns to reset values the next edge. The in-flight transaction is abandoned with no gnt/rvalid. The slave shares resetn.
- A master deasserting req before gnt is illegal. An arbitration decision already taken is not revoked.

Test Plan:
- m0-only read, addr 0x8000_0000; slave addr_ok at T+1, data_ok at T+2 with s_rdata=0x1122334455667788 -> m0_gnt at T+1, m0_rvalid and m0_rdata=0x1122334455667788 at T+2, IDLE at T+3.
- m1 write (we=0x0F, addr 0x8000_0010, wdata 0xDEADBEEF) with slave addr_ok delayed 3 cycles and data_ok delayed 2 more -> s_req held 4 cycles with stable fields, m1_gnt one pulse, m1_rvalid one pulse, m0 outputs all 0.
- RR_MODE=0, both masters requesting continuously, zero-wait slave -> every transaction granted to m1, m0 never granted while m1_req=1.
- RR_MODE=1, both masters requesting continuously -> grants alternate m0, m1, m0, m1; first grant to m0 (last_owner reset = 1). RESP->REQ direct with no IDLE cycle.
- s_data_ok pulsed during REQ before addr_ok -> ignored, no rvalid; the subsequent real data_ok in RESP produces exactly one rvalid.
- resetn low for one cycle while in RESP -> next cycle state IDLE, s_req=0, no rvalid. A later data_ok is ignored; a new m0 request then completes normally.

Source files
------------

// File: rtl/mem_arb_2x1.sv
// mem_arb_2x1: shares one sram-like slave port between two masters, one outstanding transaction.
module mem_arb_2x1 #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RR_MODE = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic [DATA_W/8-1:0] s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_addr_ok,
  input  logic                s_data_ok,
  input  logic [DATA_W-1:0]   s_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t              state;
  logic                owner, last_owner, win, arb, any;
  logic [DATA_W/8-1:0] we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata0_q, rdata1_q;
  always_comb begin
    any = m0_req || m1_req;
    arb = (state == IDLE) || (state == RESP && s_data_ok);
    win = (m0_req && m1_req) ? ((RR_MODE != 0) ? ~last_owner : 1'b1) : m1_req;
  end
  assign s_req   = state == REQ;
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  // handshake pulses are suppressed while reset is asserted so an abandoned transaction never completes
  assign m0_gnt    = resetn && state == REQ && s_addr_ok && !owner;
  assign m1_gnt    = resetn && state == REQ && s_addr_ok && owner;
  assign m0_rvalid = resetn && state == RESP && s_data_ok && !owner;
  assign m1_rvalid = resetn && state == RESP && s_data_ok && owner;
  assign m0_rdata  = m0_rvalid ? s_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? s_rdata : rdata1_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= s_rdata;
      if (m1_rvalid) rdata1_q <= s_rdata;
      if (state == REQ && s_addr_ok) state <= RESP;
      if (arb) begin
        state <= any ? REQ : IDLE;
        if (any) begin
          owner      <= win;
          last_owner <= win;
          we_q       <= win ? m1_we : m0_we;
          addr_q     <= win ? m1_addr : m0_addr;
          wdata_q    <= win ? m1_wdata : m0_wdata;
        end
      end
    end
  end
endmodule
